// File: rtl/move_entry_pkg.sv
// Shared scancode constants, entry FSM encoding and key decoding for the
// chess move-entry keyboard path (also used by the display path).
package move_entry_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXTEND    = 8'hE0;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BACKSPACE = 8'h66;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HAVE_L  = 2'd1,
        ST_HAVE_LN = 2'd2,
        ST_OFFER   = 2'd3
    } entryState_t;

    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_LETTER = 3'd1,
        KEY_DIGIT  = 3'd2,
        KEY_ENTER  = 3'd3,
        KEY_BACK   = 3'd4
    } keyKind_t;

    typedef struct packed {
        keyKind_t   kind;
        logic [2:0] index;
    } keyEvent_t;

    // Map a make code to a board key; anything unmapped comes back as KEY_NONE.
    function automatic keyEvent_t decodeKey(input logic [7:0] code);
        keyEvent_t ev;
        ev.kind  = KEY_NONE;
        ev.index = 3'd0;
        case (code)
            8'h1C: begin ev.kind = KEY_LETTER; ev.index = 3'd0; end
            8'h32: begin ev.kind = KEY_LETTER; ev.index = 3'd1; end
            8'h21: begin ev.kind = KEY_LETTER; ev.index = 3'd2; end
            8'h23: begin ev.kind = KEY_LETTER; ev.index = 3'd3; end
            8'h24: begin ev.kind = KEY_LETTER; ev.index = 3'd4; end
            8'h2B: begin ev.kind = KEY_LETTER; ev.index = 3'd5; end
            8'h34: begin ev.kind = KEY_LETTER; ev.index = 3'd6; end
            8'h33: begin ev.kind = KEY_LETTER; ev.index = 3'd7; end
            8'h16: begin ev.kind = KEY_DIGIT;  ev.index = 3'd0; end
            8'h1E: begin ev.kind = KEY_DIGIT;  ev.index = 3'd1; end
            8'h26: begin ev.kind = KEY_DIGIT;  ev.index = 3'd2; end
            8'h25: begin ev.kind = KEY_DIGIT;  ev.index = 3'd3; end
            8'h2E: begin ev.kind = KEY_DIGIT;  ev.index = 3'd4; end
            8'h36: begin ev.kind = KEY_DIGIT;  ev.index = 3'd5; end
            8'h3D: begin ev.kind = KEY_DIGIT;  ev.index = 3'd6; end
            8'h3E: begin ev.kind = KEY_DIGIT;  ev.index = 3'd7; end
            SC_ENTER:     ev.kind = KEY_ENTER;
            SC_BACKSPACE: ev.kind = KEY_BACK;
            default: ;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/move_entry_ps2_rx.sv
// PS/2 receiver: synchronises the raw keyboard lines, shifts in 11-bit frames
// on falling clock edges, checks framing/odd parity and drops stalled frames.
module ps2_rx #(
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkPrev;
    logic [9:0]    shiftReg;
    logic [3:0]    bitCnt;
    logic [TW-1:0] idleCnt;
    logic          fallEdge;
    logic          frameGood;

    assign fallEdge = clkPrev & ~clkSync[1];

    // shiftReg holds start, data[7:0], parity when the stop bit arrives.
    assign frameGood = !shiftReg[0] && dataSync[1] && (^shiftReg[9:1]);

    always_ff @(posedge clock27) begin
        if (reset) begin
            clkSync     <= 2'b11;
            dataSync    <= 2'b11;
            clkPrev     <= 1'b1;
            shiftReg    <= '0;
            bitCnt      <= '0;
            idleCnt     <= '0;
            rx_byte     <= '0;
            byte_strobe <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            clkSync     <= {clkSync[0], ps2_clk};
            dataSync    <= {dataSync[0], ps2_data};
            clkPrev     <= clkSync[1];
            byte_strobe <= 1'b0;
            frame_error <= 1'b0;
            if (fallEdge) begin
                idleCnt <= '0;
                if (bitCnt == 4'd10) begin
                    bitCnt <= '0;
                    if (frameGood) begin
                        rx_byte     <= shiftReg[8:1];
                        byte_strobe <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end else begin
                    shiftReg <= {dataSync[1], shiftReg[9:1]};
                    bitCnt   <= bitCnt + 4'd1;
                end
            end else if (bitCnt != 4'd0) begin
                // A stalled partial frame is silently abandoned.
                if (idleCnt == TW'(TIMEOUT_CYC - 1)) begin
                    bitCnt  <= '0;
                    idleCnt <= '0;
                end else begin
                    idleCnt <= idleCnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/move_entry.sv
// Keyboard move entry: decodes PS/2 scancodes into a column/row pair and
// offers the committed move to the game logic, tracking whose turn it is.
module move_entry
    import move_entry_pkg::*;
#(
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] entry_letter,
    output logic       letter_valid,
    output logic [2:0] entry_number,
    output logic       number_valid,
    output logic       move_valid,
    output logic [2:0] move_letter,
    output logic [2:0] move_number,
    input  logic       move_ack,
    input  logic       move_ok,
    output logic       player_turn,
    output logic       frame_error,
    output logic [1:0] debugState
);

    logic [7:0]  rxByte;
    logic        byteStrobe;
    logic        breakPending;
    logic        extPending;
    logic        isPrefix;
    logic        keyStrobe;
    keyEvent_t   key;
    keyKind_t    kind;
    entryState_t state;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clock27     (clock27),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rxByte),
        .byte_strobe (byteStrobe),
        .frame_error (frame_error)
    );

    assign key        = decodeKey(rxByte);
    assign isPrefix   = (rxByte == SC_BREAK) || (rxByte == SC_EXTEND);
    assign keyStrobe  = byteStrobe && !isPrefix && !breakPending && !extPending;
    assign kind       = keyStrobe ? key.kind : KEY_NONE;
    assign debugState = state;

    // Handshake: move_valid stays high with a stable payload until a cycle
    // with move_ack=1; that cycle consumes the move (move_ok decides the turn).
    always_ff @(posedge clock27) begin
        if (reset) begin
            state        <= ST_IDLE;
            breakPending <= 1'b0;
            extPending   <= 1'b0;
            entry_letter <= '0;
            entry_number <= '0;
            letter_valid <= 1'b0;
            number_valid <= 1'b0;
            move_valid   <= 1'b0;
            move_letter  <= '0;
            move_number  <= '0;
            player_turn  <= 1'b0;
        end else begin
            // Any non-prefix byte consumes pending break/extended flags.
            if (byteStrobe) begin
                if (rxByte == SC_BREAK) begin
                    breakPending <= 1'b1;
                end else if (rxByte == SC_EXTEND) begin
                    extPending <= 1'b1;
                end else begin
                    breakPending <= 1'b0;
                    extPending   <= 1'b0;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (kind == KEY_LETTER) begin
                        entry_letter <= key.index;
                        letter_valid <= 1'b1;
                        state        <= ST_HAVE_L;
                    end
                end
                ST_HAVE_L: begin
                    if (kind == KEY_LETTER) begin
                        entry_letter <= key.index;
                    end else if (kind == KEY_DIGIT) begin
                        entry_number <= key.index;
                        number_valid <= 1'b1;
                        state        <= ST_HAVE_LN;
                    end else if (kind == KEY_BACK) begin
                        entry_letter <= '0;
                        letter_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_HAVE_LN: begin
                    if (kind == KEY_LETTER) begin
                        entry_letter <= key.index;
                    end else if (kind == KEY_DIGIT) begin
                        entry_number <= key.index;
                    end else if (kind == KEY_BACK) begin
                        entry_number <= '0;
                        number_valid <= 1'b0;
                        state        <= ST_HAVE_L;
                    end else if (kind == KEY_ENTER) begin
                        move_letter <= entry_letter;
                        move_number <= entry_number;
                        move_valid  <= 1'b1;
                        state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (move_ack) begin
                        if (move_ok) begin
                            player_turn <= ~player_turn;
                        end
                        move_valid   <= 1'b0;
                        move_letter  <= '0;
                        move_number  <= '0;
                        entry_letter <= '0;
                        entry_number <= '0;
                        letter_valid <= 1'b0;
                        number_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry: PS/2 frames are bit-banged onto the raw
// keyboard lines and the entry/move outputs are compared to hand-worked values.
`timescale 1ns/1ps
module tb_move_entry;

    localparam int TIMEOUT_CYC = 100;
    localparam int HALF_BIT    = 10;

    logic       clock27  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       move_ack = 1'b0;
    logic       move_ok  = 1'b0;
    logic [2:0] entry_letter;
    logic       letter_valid;
    logic [2:0] entry_number;
    logic       number_valid;
    logic       move_valid;
    logic [2:0] move_letter;
    logic [2:0] move_number;
    logic       player_turn;
    logic       frame_error;
    logic [1:0] debugState;

    int nCompared   = 0;
    int nMismatched = 0;
    int errPulses   = 0;

    move_entry #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock27      (clock27),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .entry_letter (entry_letter),
        .letter_valid (letter_valid),
        .entry_number (entry_number),
        .number_valid (number_valid),
        .move_valid   (move_valid),
        .move_letter  (move_letter),
        .move_number  (move_number),
        .move_ack     (move_ack),
        .move_ok      (move_ok),
        .player_turn  (player_turn),
        .frame_error  (frame_error),
        .debugState   (debugState)
    );

    always #18 clock27 = ~clock27;

    // Counts cycles with frame_error high, so a single pulse adds exactly one.
    always @(posedge clock27) begin
        if (!reset && frame_error) errPulses++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock27);
    endtask

    task automatic ps2Bit(input logic b);
        ps2_data = b;
        waitCycles(HALF_BIT);
        ps2_clk = 1'b0;
        waitCycles(HALF_BIT);
        ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] code, input logic badParity);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ badParity, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2Bit(bits[i]);
        waitCycles(HALF_BIT);
    endtask

    task automatic pressKey(input logic [7:0] code);
        sendFrame(code, 1'b0);
        sendFrame(8'hF0, 1'b0);
        sendFrame(code, 1'b0);
    endtask

    task automatic pulseAck(input logic ok);
        move_ack = 1'b1;
        move_ok  = ok;
        waitCycles(1);
        move_ack = 1'b0;
        move_ok  = 1'b0;
        waitCycles(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        waitCycles(5);
        reset = 1'b0;
        waitCycles(2);
        nCompared++;
        if ({entry_letter, entry_number, move_letter, move_number} !== 12'h000) begin
            nMismatched++;
            $display("FAIL reset_payloads: got %h want 000", {entry_letter, entry_number, move_letter, move_number});
        end
        nCompared++;
        if ({letter_valid, number_valid, move_valid, player_turn, frame_error} !== 5'b00000) begin
            nMismatched++;
            $display("FAIL reset_flags: got %b want 00000", {letter_valid, number_valid, move_valid, player_turn, frame_error});
        end
        nCompared++;
        if (debugState !== 2'd0) begin
            nMismatched++;
            $display("FAIL reset_state: got %0d want 0", debugState);
        end
    endtask

    task automatic test_commit_ok();
        pressKey(8'h1C);
        nCompared++;
        if ({letter_valid, number_valid, entry_letter} !== {2'b10, 3'd0}) begin
            nMismatched++;
            $display("FAIL commit_letter: got lv=%b nv=%b l=%0d want lv=1 nv=0 l=0", letter_valid, number_valid, entry_letter);
        end
        pressKey(8'h1E);
        nCompared++;
        if ({number_valid, entry_number} !== {1'b1, 3'd1}) begin
            nMismatched++;
            $display("FAIL commit_number: got nv=%b n=%0d want nv=1 n=1", number_valid, entry_number);
        end
        pressKey(8'h5A);
        nCompared++;
        if ({move_valid, move_letter, move_number, debugState} !== {1'b1, 3'd0, 3'd1, 2'd3}) begin
            nMismatched++;
            $display("FAIL commit_offer: got v=%b l=%0d n=%0d st=%0d want v=1 l=0 n=1 st=3", move_valid, move_letter, move_number, debugState);
        end
        pulseAck(1'b1);
        nCompared++;
        if (player_turn !== 1'b1) begin
            nMismatched++;
            $display("FAIL commit_turn: got %b want 1", player_turn);
        end
        nCompared++;
        if ({move_valid, letter_valid, number_valid, entry_letter, entry_number, debugState} !== 11'd0) begin
            nMismatched++;
            $display("FAIL commit_cleared: got mv=%b lv=%b nv=%b l=%0d n=%0d st=%0d want all 0", move_valid, letter_valid, number_valid, entry_letter, entry_number, debugState);
        end
    endtask

    task automatic test_backspace_reject();
        pressKey(8'h32);
        pressKey(8'h16);
        pressKey(8'h66);
        nCompared++;
        if ({letter_valid, number_valid, entry_letter, entry_number, debugState} !== {2'b10, 3'd1, 3'd0, 2'd1}) begin
            nMismatched++;
            $display("FAIL backspace_number: got lv=%b nv=%b l=%0d n=%0d st=%0d want lv=1 nv=0 l=1 n=0 st=1", letter_valid, number_valid, entry_letter, entry_number, debugState);
        end
        pressKey(8'h3E);
        pressKey(8'h5A);
        nCompared++;
        if ({move_valid, move_letter, move_number} !== {1'b1, 3'd1, 3'd7}) begin
            nMismatched++;
            $display("FAIL reject_offer: got v=%b l=%0d n=%0d want v=1 l=1 n=7", move_valid, move_letter, move_number);
        end
        pulseAck(1'b0);
        nCompared++;
        if (player_turn !== 1'b1) begin
            nMismatched++;
            $display("FAIL reject_turn: got %b want 1", player_turn);
        end
        nCompared++;
        if ({move_valid, letter_valid, number_valid, entry_letter, entry_number} !== 9'd0) begin
            nMismatched++;
            $display("FAIL reject_cleared: got mv=%b lv=%b nv=%b l=%0d n=%0d want all 0", move_valid, letter_valid, number_valid, entry_letter, entry_number);
        end
    endtask

    task automatic test_latency();
        logic [10:0] bits;
        bits = {1'b1, ~^8'h21, 8'h21, 1'b0};
        for (int i = 0; i < 10; i++) ps2Bit(bits[i]);
        ps2_data = 1'b1;
        waitCycles(HALF_BIT);
        ps2_clk = 1'b0;
        waitCycles(3);
        nCompared++;
        if (letter_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL latency_early: got lv=%b want 0", letter_valid);
        end
        waitCycles(1);
        nCompared++;
        if ({letter_valid, entry_letter} !== {1'b1, 3'd2}) begin
            nMismatched++;
            $display("FAIL latency_on_time: got lv=%b l=%0d want lv=1 l=2", letter_valid, entry_letter);
        end
        waitCycles(HALF_BIT - 4);
        ps2_clk = 1'b1;
        waitCycles(HALF_BIT);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h21, 1'b0);
        pressKey(8'h66);
        nCompared++;
        if ({letter_valid, debugState} !== 3'b000) begin
            nMismatched++;
            $display("FAIL latency_backspace: got lv=%b st=%0d want lv=0 st=0", letter_valid, debugState);
        end
    endtask

    task automatic test_bad_parity();
        int e0;
        e0 = errPulses;
        sendFrame(8'h1C, 1'b1);
        nCompared++;
        if (errPulses - e0 !== 1) begin
            nMismatched++;
            $display("FAIL parity_error_pulse: got %0d cycles want 1", errPulses - e0);
        end
        nCompared++;
        if ({letter_valid, debugState} !== 3'b000) begin
            nMismatched++;
            $display("FAIL parity_no_capture: got lv=%b st=%0d want lv=0 st=0", letter_valid, debugState);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = errPulses;
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        waitCycles(TIMEOUT_CYC + 10);
        sendFrame(8'h1C, 1'b0);
        nCompared++;
        if ({letter_valid, entry_letter} !== {1'b1, 3'd0}) begin
            nMismatched++;
            $display("FAIL timeout_capture: got lv=%b l=%0d want lv=1 l=0", letter_valid, entry_letter);
        end
        nCompared++;
        if (errPulses !== e0) begin
            nMismatched++;
            $display("FAIL timeout_no_error: got %0d error cycles want 0", errPulses - e0);
        end
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h1C, 1'b0);
        pressKey(8'h66);
        nCompared++;
        if (debugState !== 2'd0) begin
            nMismatched++;
            $display("FAIL timeout_back_idle: got %0d want 0", debugState);
        end
    endtask

    task automatic test_ignored();
        sendFrame(8'hE0, 1'b0);
        sendFrame(8'h75, 1'b0);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h1C, 1'b0);
        pressKey(8'h16);
        pressKey(8'h5A);
        pressKey(8'h66);
        nCompared++;
        if ({letter_valid, number_valid, debugState} !== 4'b0000) begin
            nMismatched++;
            $display("FAIL idle_ignores: got lv=%b nv=%b st=%0d want 0 0 0", letter_valid, number_valid, debugState);
        end
        pulseAck(1'b1);
        nCompared++;
        if ({player_turn, debugState} !== 3'b100) begin
            nMismatched++;
            $display("FAIL ack_outside_offer: got turn=%b st=%0d want turn=1 st=0", player_turn, debugState);
        end
        pressKey(8'h24);
        pressKey(8'h3D);
        // Extended 1C (make and break) must not replace the letter.
        sendFrame(8'hE0, 1'b0);
        sendFrame(8'h1C, 1'b0);
        sendFrame(8'hE0, 1'b0);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h1C, 1'b0);
        nCompared++;
        if ({entry_letter, entry_number, debugState} !== {3'd4, 3'd6, 2'd2}) begin
            nMismatched++;
            $display("FAIL extended_ignored: got l=%0d n=%0d st=%0d want l=4 n=6 st=2", entry_letter, entry_number, debugState);
        end
        pressKey(8'h5A);
        pressKey(8'h2B);
        pressKey(8'h16);
        pressKey(8'h66);
        pressKey(8'h5A);
        nCompared++;
        if ({move_valid, move_letter, move_number, debugState} !== {1'b1, 3'd4, 3'd6, 2'd3}) begin
            nMismatched++;
            $display("FAIL offer_payload_stable: got v=%b l=%0d n=%0d st=%0d want v=1 l=4 n=6 st=3", move_valid, move_letter, move_number, debugState);
        end
        nCompared++;
        if ({letter_valid, number_valid, entry_letter, entry_number} !== {2'b11, 3'd4, 3'd6}) begin
            nMismatched++;
            $display("FAIL offer_entry_stable: got lv=%b nv=%b l=%0d n=%0d want 1 1 4 6", letter_valid, number_valid, entry_letter, entry_number);
        end
    endtask

    task automatic test_reset_offer();
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        nCompared++;
        if ({move_valid, player_turn} !== 2'b00) begin
            nMismatched++;
            $display("FAIL reset_offer_move: got mv=%b turn=%b want 0 0", move_valid, player_turn);
        end
        nCompared++;
        if ({entry_letter, entry_number, move_letter, move_number, letter_valid, number_valid, frame_error, debugState} !== 17'd0) begin
            nMismatched++;
            $display("FAIL reset_offer_outputs: got l=%0d n=%0d ml=%0d mn=%0d lv=%b nv=%b fe=%b st=%0d want all 0", entry_letter, entry_number, move_letter, move_number, letter_valid, number_valid, frame_error, debugState);
        end
        pressKey(8'h33);
        nCompared++;
        if ({letter_valid, entry_letter} !== {1'b1, 3'd7}) begin
            nMismatched++;
            $display("FAIL after_reset_capture: got lv=%b l=%0d want lv=1 l=7", letter_valid, entry_letter);
        end
    endtask

    initial begin
        test_reset();
        test_commit_ok();
        test_backspace_reject();
        test_latency();
        test_bad_parity();
        test_timeout();
        test_ignored();
        test_reset_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8192, meaning clock27 cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-002 SHALL have ports: clock27 in 1, system clock (27 MHz); reset in 1, synchronous active-high reset.
REQ-003 SHALL have ports: ps2_clk in 1, raw keyboard clock; ps2_data in 1, raw keyboard data.
REQ-004 SHALL have ports: entry_letter out 3, column index (A=0..H=7); letter_valid out 1, column held.
REQ-005 SHALL have ports: entry_number out 3, row index ('1'=0..'8'=7); number_valid out 1, row held.
REQ-006 SHALL have ports: move_valid out 1, committed move offered; move_letter out 3, move_number out 3, committed move payload.
REQ-007 SHALL have ports: move_ack in 1, game logic consumed move; move_ok in 1, move legal (sampled with move_ack).
REQ-008 SHALL have ports: player_turn out 1, 0 = player 1, 1 = player 2; frame_error out 1, one-cycle pulse on a bad frame.
REQ-009 Clock is clock27, single domain; reset is synchronous and active-high.

Function
REQ-010 SHALL synchronise ps2_clk and ps2_data through two flops each; a PS/2 falling edge is detected on the synchronised clock.
REQ-011 SHALL receive 11-bit frames on falling edges: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-012 Byte SHALL be delivered internally one cycle after the stop-bit edge if start=0, parity odd and stop=1; otherwise frame_error pulses one cycle and the byte is dropped.
REQ-013 Partial frame SHALL be discarded without error when TIMEOUT_CYC cycles pass between edges; the bit counter returns to 0.
REQ-014 Byte 0xF0 SHALL set break-pending; the next byte is consumed and ignored. Byte 0xE0 SHALL set extended-pending; the next byte (and its break) is ignored.
REQ-015 Key map: A..H = 1C,32,21,23,24,2B,34,33; '1'..'8' = 16,1E,26,25,2E,36,3D,3E; Enter = 5A; Backspace = 66. All other make codes are ignored.
REQ-016 Entry FSM states: IDLE, HAVE_L, HAVE_LN, OFFER.
REQ-017 IDLE: letter -> capture, HAVE_L. Digit, Enter and Backspace are ignored.
REQ-018 HAVE_L: letter -> replace; digit -> capture, HAVE_LN; Backspace -> clear letter, IDLE; Enter ignored.
REQ-019 HAVE_LN: digit -> replace; letter -> replace letter, keep number; Backspace -> clear number, HAVE_L; Enter -> load move_letter/move_number, OFFER.
REQ-020 OFFER: move_valid SHALL be 1 and payload stable; all keys ignored; payload lives only in this state.
REQ-021 OFFER with move_ack=1: if move_ok=1, player_turn toggles on the same edge. Either way the FSM goes to IDLE with entry cleared and move_valid=0 next cycle.
REQ-022 letter_valid SHALL be 1 in HAVE_L, HAVE_LN and OFFER; number_valid SHALL be 1 in HAVE_LN and OFFER.
REQ-023 move_ack outside OFFER SHALL be ignored.
REQ-024 Latency: key stop-bit edge to entry outputs updated SHALL be 2 cycles.

Reset
REQ-025 Reset SHALL force: FSM IDLE; entry_letter, entry_number, move_letter, move_number = 0; all valids 0; player_turn 0; frame_error 0.
REQ-026 Reset SHALL clear the receiver bit counter, timeout counter, and break/extended flags, dropping any frame in flight.
REQ-027 Reset mid-OFFER SHALL drop the move with no player_turn toggle.

Structure
REQ-028 Scancode constants and FSM state encodings SHALL live in a shared package for reuse by the display path.
REQ-029 A sub-module ps2_rx SHALL contain synchroniser, framing, parity and timeout; it outputs byte and a byte_strobe. move_entry holds decode and FSM.

Verification
REQ-030 Frames 1C, 1E, 5A (each followed by F0+code) -> move_valid=1 with letter 0, number 1; ack with ok=1 -> player_turn 0->1, back to IDLE.
REQ-031 Frames 32, 16, 66, 3E, 5A -> move letter 1, number 7; ack with ok=0 -> player_turn unchanged, entry cleared.
REQ-032 Frame with bad parity for 1C -> frame_error one pulse; letter_valid stays 0.
REQ-033 Send 4 bits then idle TIMEOUT_CYC+10 cycles, then valid 1C frame -> letter 0 captured, no frame_error.
REQ-034 E0 75 and F0 1C with FSM in IDLE -> no state change; keys sent while in OFFER -> payload unchanged.
REQ-035 Assert reset during OFFER -> move_valid 0 next cycle, player_turn 0, all outputs at reset values.
